// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite initiator.
//   axil_m_state_t : initiator FSM states
//   AXI_RESP_*     : AXI response codes
package axil_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } axil_m_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_resp_timer.sv
// Response-wait timer shared by the write-response and read-data phases.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : force the count back to zero
//   enable    : count this cycle (saturates, never wraps)
//   expired   : this is the last allowed wait cycle (count == TIMEOUT_CYCLES-1)
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module axil_resp_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES > 0) && enable && (count_q == LAST);

endmodule

// File: rtl/axil_master_fsm.sv
// AXI4-Lite initiator: accepts one read/write command, runs the matching
// AXI-Lite transaction, and returns data/status on a response port.
// Ports:
//   m_axil_clk, m_axil_rst           : clock, asynchronous active-high reset
//   cmd_valid/ready/rw/addr/wdata/wstrb : command port (rw=1 write)
//   rsp_valid/ready/rdata/resp/timeout  : response port
//   m_axil_aw*/w*/b*/ar*/r*          : AXI4-Lite master channels
// One transaction outstanding; all outputs are registered.
module axil_master_fsm
  import axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    m_axil_clk,
  input  logic                    m_axil_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  axil_m_state_t state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  logic timer_run, timer_expired;
  logic aw_hs, w_hs, aw_done_now, w_done_now;

  // The timer only runs while waiting for B or R; any other state holds it
  // at zero, which gives the clear-on-entry behaviour for free.
  assign timer_run = (state_q == ST_WR_RESP) || (state_q == ST_RD_DATA);

  axil_resp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (m_axil_clk),
    .rst    (m_axil_rst),
    .clear  (~timer_run),
    .enable (timer_run),
    .expired(timer_expired)
  );

  assign aw_hs       = awvalid_q & m_axil_awready;
  assign w_hs        = wvalid_q & m_axil_wready;
  // Include this cycle's handshakes so bready can rise on the same edge.
  assign aw_done_now = aw_done_q | aw_hs;
  assign w_done_now  = w_done_q | w_hs;

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cmd_ready_d = 1'b0;
          if (cmd_rw) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end

      ST_WR_REQ: begin
        aw_done_d = aw_done_now;
        w_done_d  = w_done_now;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_done_now && w_done_now) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        // A handshake on the expiry cycle takes priority over the timeout.
        if (m_axil_bvalid && bready_q) begin
          bready_d      = 1'b0;
          rsp_resp_d    = m_axil_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RSP;
        end else if (timer_expired) begin
          bready_d      = 1'b0;
          rsp_resp_d    = AXI_RESP_SLVERR;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RSP;
        end
      end

      ST_RD_REQ: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (m_axil_rvalid && rready_q) begin
          rready_d      = 1'b0;
          rsp_resp_d    = m_axil_rresp;
          rsp_rdata_d   = m_axil_rdata;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RSP;
        end else if (timer_expired) begin
          rready_d      = 1'b0;
          rsp_resp_d    = AXI_RESP_SLVERR;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge m_axil_clk or posedge m_axil_rst) begin
    if (m_axil_rst) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: doc/axil_master_fsm.md
Name: axil_master_fsm

Overview:
AXI4-Lite initiator that drives the same 5-channel interface our AXI-Lite slave front-end accepts.
- A simple command port (valid/ready) takes one read or write request.
- The block runs the matching AXI-Lite transaction and returns data and status on a response port (valid/ready).
- It serves as the bus-side stimulus engine for the AXI2SDRAM wrapper and as a register-access master for init/BIST logic.
- One transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; multiple of 8
- TIMEOUT_CYCLES, 1024, max cycles waiting for bvalid/rvalid; 0 disables timeout

Ports:
- m_axil_clk  in  1  clock
- m_axil_rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_rw  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  AXI resp code, or SLVERR on timeout
- rsp_timeout  out  1  transaction ended by timeout
- m_axil_awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  write address channel
- m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- m_axil_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
- m_axil_araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  read address channel
- m_axil_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- All outputs registered.
- Reset (async, m_axil_rst=1): state IDLE; all valid/ready outputs 0, except cmd_ready=1 after reset release; addr/data/strb/rdata/resp outputs 0; rsp_timeout 0; timer 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr/wdata/wstrb; cmd_ready<=0.
  - Write: awvalid<=1, wvalid<=1, next WR_REQ.
  - Read: arvalid<=1, next RD_REQ.
  - The first valid is visible the cycle after cmd acceptance.
- WR_REQ:
  - AW and W handshake independently.
  - awvalid drops the cycle after awvalid&awready; wvalid likewise; aw_done/w_done flags track them.
  - Both may complete in the same cycle.
  - Once both are done (including the same edge as the last handshake), bready<=1 and go to WR_RESP.
  - Valids never drop before their handshake; no timeout in this state.
- WR_RESP:
  - Timer counts each cycle.
  - On bvalid&bready: capture bresp into rsp_resp, rsp_rdata<=0, bready<=0, rsp_valid<=1, go to RSP.
  - If the timer reaches TIMEOUT_CYCLES-1 without bvalid: bready<=0, rsp_resp<=2'b10, rsp_timeout<=1, rsp_valid<=1, go to RSP.
  - If bvalid arrives on the timeout cycle, the handshake wins.
- RD_REQ: on arvalid&arready, arvalid<=0, rready<=1, go to RD_DATA; no timeout.
- RD_DATA:
  - Same as WR_RESP, using rvalid/rready.
  - Capture rdata and rresp.
  - On timeout: rsp_rdata<=0, SLVERR.
- RSP:
  - Hold rsp_* stable while rsp_valid&~rsp_ready.
  - On rsp_ready: rsp_valid<=0, rsp_timeout<=0, cmd_ready<=1, go to IDLE.
  - Minimum turnaround is 1 idle cycle between responses.
- Timer:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to WR_RESP/RD_DATA; never wraps.
  - With TIMEOUT_CYCLES=0 it is disabled and the block waits forever.
- Reset mid-transaction: all channel valids/readies drop immediately (async); any pending command and response are discarded.
- Slave responses other than OKAY are passed through unchanged with rsp_timeout=0.

Decomposition:
- Package axil_master_pkg:
  - state enum axil_m_state_t.
  - resp constants AXI_RESP_OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Command struct, optional.
- Sub-module axil_resp_timer: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES; instantiated once and shared by WR_RESP and RD_DATA.

Test Plan:
- Write addr 0x0000_0010, wdata 0xA5A5_1234, wstrb 0xF; slave raises awready and wready in the same cycle, bresp OKAY -> exactly one AW and one W handshake; rsp_valid with rsp_resp=00, rsp_rdata=0, rsp_timeout=0.
- Write with wready delayed 5 cycles after the AW handshake -> awvalid low after AW; wvalid held 5 cycles with wdata/wstrb stable; bready asserted only after the W handshake.
- Read addr 0x0000_0020; slave returns rdata 0xDEAD_BEEF, rresp 00 after 3 cycles -> rsp_rdata=0xDEAD_BEEF, rsp_resp=00; cmd_ready stays 0 until rsp_ready.
- rsp_ready held low 10 cycles -> rsp_valid and rsp_rdata stable for all 10; a new cmd_valid is ignored (cmd_ready=0) until one cycle after rsp_ready.
- TIMEOUT_CYCLES=16, slave never asserts rvalid -> rready drops after 16 cycles in RD_DATA; rsp_resp=10, rsp_timeout=1, rsp_rdata=0; a following write completes normally.
- Assert m_axil_rst while awvalid=1 and wvalid=1 -> both 0 immediately, no response emitted; after release cmd_ready=1 and a new read completes.
